// File: rtl/rf_pkg.sv
// Shared sizing and types for the RV64I integer register file and its busy scoreboard.
package rf_pkg;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = $clog2(NREG);

   typedef logic [XLEN-1:0] xlen_t;
   typedef logic [AW-1:0]   ridx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered popcount.
// Priority per index is flush, then issue, then writeback. x0 is never busy.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREG = rf_pkg::NREG,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_idx,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   output logic [NREG-1:0] busy,
   output logic [AW:0]     busy_cnt
);

   logic [NREG-1:0] busy_d;
   logic [AW:0]     cnt_d;

   always_comb begin
      busy_d = busy;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (wb_en)
            busy_d[wb_idx] = 1'b0;
         // Issue is applied last so a newer producer wins over a same-cycle writeback.
         if (iss_en)
            busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NREG; i++)
         cnt_d = cnt_d + (AW+1)'(busy_d[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_d;
         busy_cnt <= cnt_d;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write port and a busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int XLEN = rf_pkg::XLEN,
   parameter int NREG = rf_pkg::NREG,
   parameter int NRD  = rf_pkg::NRD,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_en,
   input  logic [AW-1:0]       wb_idx,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   input  logic [NRD*AW-1:0]   rs_idx,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   output logic [AW:0]         busy_cnt
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;

   rf_scoreboard #(.NREG(NREG)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wb_en    (wb_en),
      .wb_idx   (wb_idx),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .flush    (flush),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

   // regs[0] is reset and never written, so it reads as zero without a special case.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wb_en && wb_idx != '0) begin
         regs[wb_idx] <= wb_data;
      end
   end

   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         rs_data[k*XLEN +: XLEN] = regs[rs_idx[k*AW +: AW]];
         rs_busy[k]              = busy[rs_idx[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         if (wb_en && wb_idx == rs_idx[k*AW +: AW] && wb_idx != '0) begin
            rs_data[k*XLEN +: XLEN] = wb_data;
            rs_busy[k]              = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, reset corners and a random run against a model.
module tb_regfile_sb;
   import rf_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                wb_en;
   logic [AW-1:0]       wb_idx;
   logic [XLEN-1:0]     wb_data;
   logic                iss_en;
   logic [AW-1:0]       iss_rd;
   logic                flush;
   logic [NRD*AW-1:0]   rs_idx;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic [AW:0]         busy_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk      (clk),
      .rst      (rst),
      .wb_en    (wb_en),
      .wb_idx   (wb_idx),
      .wb_data  (wb_data),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .flush    (flush),
      .rs_idx   (rs_idx),
      .rs_data  (rs_data),
      .rs_busy  (rs_busy),
      .busy_cnt (busy_cnt)
   );

   typedef struct {
      logic          wb_en;
      logic [AW-1:0] wb_idx;
      logic [63:0]   wb_data;
      logic          iss_en;
      logic [AW-1:0] iss_rd;
      logic          flush;
      logic [AW-1:0] r0, r1;
      logic [63:0]   d0, d1;
      logic          b0, b1;
      logic [AW:0]   cnt;
   } vec_t;

   vec_t tv[$];

   // reference model state
   logic [63:0] m_regs [NREG];
   logic        m_busy [NREG];
   int          m_cnt;

   function automatic vec_t mk(input logic we, input int wi, input logic [63:0] wd,
                               input logic ie, input int ir, input logic fl,
                               input int r0, input int r1,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic b0, input logic b1, input int cnt);
      vec_t v;
      v.wb_en = we; v.wb_idx = AW'(wi); v.wb_data = wd;
      v.iss_en = ie; v.iss_rd = AW'(ir); v.flush = fl;
      v.r0 = AW'(r0); v.r1 = AW'(r1);
      v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.cnt = (AW+1)'(cnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      wb_en = 0; wb_idx = '0; wb_data = '0;
      iss_en = 0; iss_rd = '0; flush = 0;
   endtask

   function automatic logic [63:0] exp_data(input logic [AW-1:0] idx);
      if (BYP && wb_en && wb_idx == idx && idx != '0) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] idx);
      if (BYP && wb_en && wb_idx == idx && idx != '0) return 1'b0;
      return m_busy[idx];
   endfunction

   task automatic model_step();
      logic nb [NREG];
      if (wb_en && wb_idx != '0) m_regs[wb_idx] = wb_data;
      for (int i = 0; i < NREG; i++) begin
         if (flush)                                         nb[i] = 1'b0;
         else if (i != 0 && iss_en && int'(iss_rd) == i)    nb[i] = 1'b1;
         else if (wb_en && int'(wb_idx) == i)               nb[i] = 1'b0;
         else                                               nb[i] = m_busy[i];
      end
      m_cnt = 0;
      for (int i = 0; i < NREG; i++) begin
         m_busy[i] = nb[i];
         if (nb[i]) m_cnt++;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_cnt = 0;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      rs_idx = '0;
      model_reset();

      // reset held with traffic: nothing may stick
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         wb_en = 1; wb_idx = AW'($urandom_range(1, NREG-1)); wb_data = {$urandom, $urandom};
         iss_en = 1; iss_rd = AW'($urandom_range(1, NREG-1));
         rs_idx = {wb_idx, iss_rd};
         #3;
         chk($sformatf("rst_d0_c%0d", c), rs_data[0 +: XLEN], 64'h0);
         chk($sformatf("rst_d1_c%0d", c), rs_data[XLEN +: XLEN], 64'h0);
         chk($sformatf("rst_b_c%0d", c), 64'(rs_busy), 64'h0);
         chk($sformatf("rst_cnt_c%0d", c), 64'(busy_cnt), 64'h0);
      end
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b1;

      tv.push_back(mk(1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 5, 5,
                      BYP ? 64'hDEAD_BEEF_0000_0001 : 64'h0, BYP ? 64'hDEAD_BEEF_0000_0001 : 64'h0, 0, 0, 0));
      tv.push_back(mk(1, 0, 64'h1, 0, 0, 0, 5, 0, 64'hDEAD_BEEF_0000_0001, 64'h0, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 0, 5, 64'h0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 1, 7, 0, 7, 0, 64'h0, 64'h0, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 7, 7, 64'h0, 64'h0, 1, 1, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 7, 7, 64'h0, 64'h0, 1, 1, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 7, 7, 64'h0, 64'h0, 1, 1, 1));
      tv.push_back(mk(1, 7, 64'h42, 0, 0, 0, 7, 7, BYP ? 64'h42 : 64'h0, BYP ? 64'h42 : 64'h0, !BYP, !BYP, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 7, 7, 64'h42, 64'h42, 0, 0, 0));
      tv.push_back(mk(1, 9, 64'h99, 1, 9, 0, 9, 9, BYP ? 64'h99 : 64'h0, BYP ? 64'h99 : 64'h0, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 9, 9, 64'h99, 64'h99, 1, 1, 1));
      tv.push_back(mk(0, 0, 64'h0, 1, 3, 1, 9, 3, 64'h99, 64'h0, 1, 0, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 9, 3, 64'h99, 64'h0, 0, 0, 0));
      tv.push_back(mk(1, 12, 64'hABCD, 0, 0, 0, 12, 9, BYP ? 64'hABCD : 64'h0, 64'h99, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 12, 12, 64'hABCD, 64'hABCD, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 1, 4, 0, 4, 0, 64'h0, 64'h0, 0, 0, 0));
      tv.push_back(mk(1, 4, 64'h55, 0, 0, 1, 4, 0, BYP ? 64'h55 : 64'h0, 64'h0, !BYP, 0, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 4, 4, 64'h55, 64'h55, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 1, 10, 0, 10, 0, 64'h0, 64'h0, 0, 0, 0));
      tv.push_back(mk(0, 0, 64'h0, 1, 10, 0, 10, 0, 64'h0, 64'h0, 1, 0, 1));
      tv.push_back(mk(0, 0, 64'h0, 1, 0, 0, 10, 0, 64'h0, 64'h0, 1, 0, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 10, 0, 64'h0, 64'h0, 1, 0, 1));
      tv.push_back(mk(1, 10, 64'h7, 0, 0, 0, 0, 10, 64'h0, BYP ? 64'h7 : 64'h0, 0, !BYP, 1));
      tv.push_back(mk(0, 0, 64'h0, 0, 0, 0, 0, 10, 64'h0, 64'h7, 0, 0, 0));

      foreach (tv[i]) begin
         wb_en = tv[i].wb_en; wb_idx = tv[i].wb_idx; wb_data = tv[i].wb_data;
         iss_en = tv[i].iss_en; iss_rd = tv[i].iss_rd; flush = tv[i].flush;
         rs_idx = {tv[i].r1, tv[i].r0};
         #3;
         chk($sformatf("v%0d_d0", i), rs_data[0 +: XLEN], tv[i].d0);
         chk($sformatf("v%0d_d1", i), rs_data[XLEN +: XLEN], tv[i].d1);
         chk($sformatf("v%0d_b0", i), 64'(rs_busy[0]), 64'(tv[i].b0));
         chk($sformatf("v%0d_b1", i), 64'(rs_busy[1]), 64'(tv[i].b1));
         chk($sformatf("v%0d_cnt", i), 64'(busy_cnt), 64'(tv[i].cnt));
         model_step();
         @(posedge clk); #1;
      end

      // random traffic; indices biased low so hazards collide often
      for (int c = 0; c < 10000; c++) begin
         wb_en   = ($urandom_range(0, 2) != 0);
         wb_idx  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wb_data = {$urandom, $urandom};
         iss_en  = ($urandom_range(0, 1) != 0);
         iss_rd  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         flush   = ($urandom_range(0, 31) == 0);
         rs_idx  = {AW'($urandom_range(0, 9)), ($urandom_range(0, 1) != 0) ? wb_idx : AW'($urandom)};
         #3;
         for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rnd%0d_d%0d", c, k), rs_data[k*XLEN +: XLEN], exp_data(rs_idx[k*AW +: AW]));
            chk($sformatf("rnd%0d_b%0d", c, k), 64'(rs_busy[k]), 64'(exp_busy(rs_idx[k*AW +: AW])));
         end
         chk($sformatf("rnd%0d_cnt", c), 64'(busy_cnt), 64'(m_cnt));
         model_step();
         @(posedge clk); #1;
      end

      // make sure there is pending state, then reset asynchronously between edges
      idle_inputs();
      iss_en = 1; iss_rd = AW'(13); wb_en = 1; wb_idx = AW'(14); wb_data = 64'h1234;
      @(posedge clk); #1;
      idle_inputs();
      rs_idx = {AW'(14), AW'(13)};
      #1;
      chk("pre_rst_b0", 64'(rs_busy[0]), 64'h1);
      chk("pre_rst_d1", rs_data[XLEN +: XLEN], 64'h1234);
      rst = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_d1", rs_data[XLEN +: XLEN], 64'h0);
      chk("mid_rst_b0", 64'(rs_busy[0]), 64'h0);
      chk("mid_rst_cnt", 64'(busy_cnt), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
